// File: rtl/tdp_mem_be.sv
// rtl/tdp_mem_be.sv - true dual-port RAM with byte enables, RDW mode, optional output stage and clear sequencer
module tdp_mem_be #(
  parameter int MEM_SIZE      = 1024,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int RDW_MODE      = 0,
  parameter int OUT_REG       = 0,
  parameter int INIT_ON_RESET = 1,
  localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
  localparam int NB = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  ena,
  input  logic                  wa,
  input  logic [NB-1:0]         bea,
  input  logic [AW-1:0]         aa,
  input  logic [DATA_WIDTH-1:0] da,
  output logic [DATA_WIDTH-1:0] qa,
  output logic                  qva,
  input  logic                  enb,
  input  logic                  wb,
  input  logic [NB-1:0]         beb,
  input  logic [AW-1:0]         ab,
  input  logic [DATA_WIDTH-1:0] db,
  output logic [DATA_WIDTH-1:0] qb,
  output logic                  qvb,
  output logic                  collision
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [0:0] ST_RESET = (INIT_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic [AW:0] MEM_LAST = (AW+1)'(MEM_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;

  logic                  inr_a, inr_b;
  logic                  acc_a, acc_b;
  logic                  wr_a, wr_b;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] new_a, new_b;
  logic [DATA_WIDTH-1:0] ret_a, ret_b;

  logic [DATA_WIDTH-1:0] qa1_q, qa1_d, qa2_q, qa2_d;
  logic [DATA_WIDTH-1:0] qb1_q, qb1_d, qb2_q, qb2_d;
  logic                  qva1_q, qva1_d, qva2_q, qva2_d;
  logic                  qvb1_q, qvb1_d, qvb2_q, qvb2_d;
  logic                  col_q, col_d;

  // Clear sequencer: one zero word per cycle, then hand the array to the ports.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we = 1'b1;
      if ({1'b0, cnt_q} == MEM_LAST) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign ready = (state_q == ST_READY);

  generate
    if (MEM_SIZE == (1 << AW)) begin : g_pow2
      assign inr_a = 1'b1;
      assign inr_b = 1'b1;
    end else begin : g_npow2
      localparam logic [AW:0] MEM_WORDS = (AW+1)'(MEM_SIZE);
      assign inr_a = ({1'b0, aa} < MEM_WORDS);
      assign inr_b = ({1'b0, ab} < MEM_WORDS);
    end
  endgenerate

  assign acc_a = ready & ena;
  assign acc_b = ready & enb;
  assign wr_a  = acc_a & wa & inr_a;
  assign wr_b  = acc_b & wb & inr_b;
  assign old_a = inr_a ? mem[aa] : '0;
  assign old_b = inr_b ? mem[ab] : '0;

  // Each port sees only its own lanes merged; a reader always sees the pre-edge word.
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (bea[i]) new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = da[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (beb[i]) new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = db[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    ret_a = '0;
    ret_b = '0;
    if (inr_a) ret_a = (wa && RDW_MODE == 0) ? new_a : old_a;
    if (inr_b) ret_b = (wb && RDW_MODE == 0) ? new_b : old_b;
  end

  always_comb begin
    qva1_d = acc_a;
    qvb1_d = acc_b;
    qa1_d  = acc_a ? ret_a : qa1_q;
    qb1_d  = acc_b ? ret_b : qb1_q;
    qva2_d = qva1_q;
    qvb2_d = qvb1_q;
    qa2_d  = qva1_q ? qa1_q : qa2_q;
    qb2_d  = qvb1_q ? qb1_q : qb2_q;
    col_d  = acc_a & acc_b & inr_a & (aa == ab) & ((wa & (|bea)) | (wb & (|beb)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      qa1_q   <= '0;
      qb1_q   <= '0;
      qa2_q   <= '0;
      qb2_q   <= '0;
      qva1_q  <= 1'b0;
      qvb1_q  <= 1'b0;
      qva2_q  <= 1'b0;
      qvb2_q  <= 1'b0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qa1_q   <= qa1_d;
      qb1_q   <= qb1_d;
      qa2_q   <= qa2_d;
      qb2_q   <= qb2_d;
      qva1_q  <= qva1_d;
      qvb1_q  <= qvb1_d;
      qva2_q  <= qva2_d;
      qvb2_q  <= qvb2_d;
      col_q   <= col_d;
    end
  end

  // Port B lanes are written last so they win on a same-address overlap.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_a && bea[i]) mem[aa][i*BYTE_WIDTH +: BYTE_WIDTH] <= da[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_b && beb[i]) mem[ab][i*BYTE_WIDTH +: BYTE_WIDTH] <= db[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign qa        = (OUT_REG != 0) ? qa2_q  : qa1_q;
  assign qb        = (OUT_REG != 0) ? qb2_q  : qb1_q;
  assign qva       = (OUT_REG != 0) ? qva2_q : qva1_q;
  assign qvb       = (OUT_REG != 0) ? qvb2_q : qvb1_q;
  assign collision = col_q;

endmodule

// File: doc/tdp_mem_be.md
Name: tdp_mem_be

Overview:
- Next-generation true dual-port RAM for the switch packet/queue buffers.
- Adds per-byte write enables, a selectable read-during-write mode, an optional output register stage and a cross-port collision flag.
- Adds a post-reset clear sequencer that zeroes every word before either port is accepted.
- Sits under the crossbar/VOQ logic. Each port is owned by one client (e.g. ingress writer on A, egress reader on B).

Parameters:
- MEM_SIZE, 1024: number of words; address width AW = $clog2(MEM_SIZE).
- DATA_WIDTH, 32: bits per word; must be an integer multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH lanes.
- RDW_MODE, 0: same-port read-during-write. 0 = write-first (q returns merged new word); 1 = read-first (q returns old word).
- OUT_REG, 0: 0 = read latency 1 cycle; 1 = read latency 2 cycles (extra output flop).
- INIT_ON_RESET, 1: 1 = clear all words to zero after reset; 0 = contents undefined, ready immediately.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- ready  out  1  high when ports accept requests
- ena  in  1  port A request strobe
- wa  in  1  port A write (valid only with ena)
- bea  in  NB  port A byte-lane write enables
- aa  in  AW  port A address
- da  in  DATA_WIDTH  port A write data
- qa  out  DATA_WIDTH  port A read data
- qva  out  1  port A read-data valid pulse
- enb, wb, beb, ab, db, qb, qvb  same as port A, for port B
- collision  out  1  same-address conflict pulse

Behaviour:
- Reset values (asynchronous assert): qa=qb=0, qva=qvb=0, collision=0, all pipeline valids cleared. ready=0 if INIT_ON_RESET=1, else ready=1. Memory contents are not reset directly.
- Clear FSM (INIT_ON_RESET=1), states CLEAR and READY:
  - Leaving reset enters CLEAR with counter=0.
  - CLEAR writes all-zero to word[counter] each cycle and increments counter.
  - After word MEM_SIZE-1 is written, the FSM goes to READY and sets ready=1. ready first samples high exactly MEM_SIZE cycles after reset deassert.
  - Reset asserted mid-CLEAR restarts from counter=0.
  - During CLEAR, ena/enb are ignored: no writes, no qv pulses, collision stays 0.
- Request accepted when ready && en.
  - Write (w=1): each lane i with be[i]=1 takes d[i*BYTE_WIDTH +: BYTE_WIDTH]; lanes with be[i]=0 keep their stored value.
  - Every accepted request, read or write, returns a word on q with a qv pulse.
  - Write with be=0: no memory change; returns the old word.
- Latency: qv pulses exactly 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) after the accepting edge, one pulse per request. Back-to-back requests give back-to-back pulses, full throughput.
- q holds its last value when qv=0 and never changes without a qv pulse.
- Same-port write data returned:
  - RDW_MODE=0: merged post-write word.
  - RDW_MODE=1: pre-write word.
- Cross-port, same address, both accepted in the same cycle:
  - Write vs write: lanes enabled on only one port take that port's data; lanes enabled on both take port B data. Each port's q follows its own RDW_MODE rule using its own view of the write.
  - Read vs write: the reading port returns the pre-write word regardless of RDW_MODE; the writing port follows RDW_MODE.
  - Read vs read: no conflict, collision=0.
  - collision pulses 1 cycle after the edge (independent of OUT_REG) when at least one port writes with be≠0.
- Address ≥ MEM_SIZE (non-power-of-2 MEM_SIZE): write is dropped, read returns 0, qv still pulses.
- Reset asserted mid-pipeline: in-flight qv pulses are dropped and no late pulse appears after release.

Test Plan:
- Init: INIT_ON_RESET=1, MEM_SIZE=16, release reset. ready rises on cycle 16; reads of addr 0..15 return 0x00000000; ena pulses during CLEAR produce no qva.
- Byte enables: write A addr 3 da=0xAABBCCDD be=1111, then write addr 3 da=0x11223344 be=0101. Read B addr 3 returns 0xAA22CC44 with qvb 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
- RDW mode: addr 5 holds 0x12345678; A writes 0xDEADBEEF be=1111. qa=0xDEADBEEF with RDW_MODE=0 and 0x12345678 with RDW_MODE=1.
- Cross-port: addr 7 holds 0; same cycle A writes 0x000000FF be=0011 and B writes 0x0000AB00 be=0010. Memory ends 0x0000ABFF; collision pulses once.
- Read-vs-write: addr 9 holds 0x55; A reads while B writes 0x66. qa=0x55, collision=1; the next read returns 0x66.
- Reset abort: assert reset mid-CLEAR at counter=8 and mid-read. qv stays 0, ready=0, and the clear restarts and takes the full 16 cycles.
